i2cmb_wb_sequencer: RTL and testbench

Synthesizable Wishbone master that sits directly upstream of the I2C multi-bus controller (iicmb_m_wb). It turns byte-level I2C transaction requests (bus, slave address, direction, length) into the CSR/DPR/CMDR register sequence: enable, set bus, start, address, data bytes, stop. Completion of each step is detected by waiting on the controller's irq and reading CMDR. Write data and read data move over valid/ready streams, and each request ends in a done or error pulse.

---
 rtl/i2cmb_wb_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_i2cmb_wb_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_wb_sequencer.sv
// Wishbone master that drives the iicmb_m_wb register interface to run byte-level
// I2C read/write transactions, with valid/ready byte streams and a done/err pulse.
module i2cmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int LEN_WIDTH      = 6,
    parameter int IRQ_TIMEOUT    = 65535
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [3:0]                req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_rd_i,
    input  logic [LEN_WIDTH-1:0]      req_len_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [7:0]                wr_data_i,
    output logic                      rd_valid_o,
    input  logic                      rd_ready_i,
    output logic [7:0]                rd_data_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);
    localparam int TW = $clog2(IRQ_TIMEOUT + 1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);

    typedef enum logic [3:0] {
        S_INIT_CSR, S_IDLE, S_SET_BUS, S_START, S_ADDR, S_WDATA, S_RDATA,
        S_RD_DPR, S_RD_OUT, S_STOP, S_FINISH, S_CMD, S_WAIT_IRQ, S_CHK_CMDR
    } state_t;

    // Which command is in flight, so the shared WAIT_IRQ/CHK_CMDR path knows where to go next.
    typedef enum logic [2:0] {P_BUS, P_START, P_ADDR, P_WR, P_RD, P_STOP} phase_t;

    state_t                    state_q, state_d;
    phase_t                    ph_q, ph_d;
    logic [7:0]                cmd_q, cmd_d;
    logic [3:0]                bus_q, bus_d;
    logic [I2C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      rd_q, rd_d;
    logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
    logic [7:0]                wbyte_q, wbyte_d;
    logic                      have_q, have_d;
    logic [7:0]                rdata_q, rdata_d;
    logic [1:0]                code_q, code_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic                      irq_q;
    logic                      cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0]  adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0]  dat_q, dat_d;

    logic                      acc_req, acc_we, ack_cyc;
    logic [WB_ADDR_WIDTH-1:0]  acc_adr;
    logic [WB_DATA_WIDTH-1:0]  acc_dat;

    assign ack_cyc = cyc_q & ack_i;

    always_comb begin
        state_d = state_q;  ph_d = ph_q;  cmd_d = cmd_q;  bus_d = bus_q;
        addr_d = addr_q;  rd_d = rd_q;  cnt_d = cnt_q;  wbyte_d = wbyte_q;
        have_d = have_q;  rdata_d = rdata_q;  code_d = code_q;  tmo_d = tmo_q;
        cyc_d = cyc_q;  stb_d = stb_q;  we_d = we_q;  adr_d = adr_q;  dat_d = dat_q;
        acc_req = 1'b0;  acc_we = 1'b0;  acc_adr = A_CSR;  acc_dat = '0;

        case (state_q)
            S_INIT_CSR: begin
                acc_req = 1'b1;  acc_we = 1'b1;  acc_adr = A_CSR;
                acc_dat = WB_DATA_WIDTH'(8'hC0);
                if (ack_cyc) state_d = S_IDLE;
            end
            S_IDLE: if (req_valid_i) begin
                bus_d   = req_bus_i;
                addr_d  = req_addr_i;
                rd_d    = req_rd_i;
                cnt_d   = (int'(req_len_i) > 32) ? LEN_WIDTH'(32) : req_len_i;
                code_d  = 2'd0;
                state_d = S_SET_BUS;
            end
            S_SET_BUS: begin
                acc_req = 1'b1;  acc_we = 1'b1;  acc_adr = A_DPR;
                acc_dat = WB_DATA_WIDTH'(bus_q);
                if (ack_cyc) begin cmd_d = 8'h06; ph_d = P_BUS; state_d = S_CMD; end
            end
            S_START: begin cmd_d = 8'h04; ph_d = P_START; state_d = S_CMD; end
            S_ADDR: begin
                acc_req = 1'b1;  acc_we = 1'b1;  acc_adr = A_DPR;
                acc_dat = WB_DATA_WIDTH'({addr_q, rd_q});
                if (ack_cyc) begin cmd_d = 8'h01; ph_d = P_ADDR; state_d = S_CMD; end
            end
            S_WDATA: begin
                if (!have_q) begin
                    if (wr_valid_i) begin wbyte_d = wr_data_i; have_d = 1'b1; end
                end else begin
                    acc_req = 1'b1;  acc_we = 1'b1;  acc_adr = A_DPR;
                    acc_dat = WB_DATA_WIDTH'(wbyte_q);
                    if (ack_cyc) begin
                        have_d = 1'b0;  cmd_d = 8'h01;  ph_d = P_WR;  state_d = S_CMD;
                    end
                end
            end
            S_RDATA: begin
                // Last byte of a read is NAKed by the master to end the transfer.
                cmd_d   = (cnt_q == LEN_WIDTH'(1)) ? 8'h03 : 8'h02;
                ph_d    = P_RD;
                state_d = S_CMD;
            end
            S_STOP: begin cmd_d = 8'h05; ph_d = P_STOP; state_d = S_CMD; end
            S_CMD: begin
                acc_req = 1'b1;  acc_we = 1'b1;  acc_adr = A_CMDR;
                acc_dat = WB_DATA_WIDTH'(cmd_q);
                if (ack_cyc) begin tmo_d = '0; state_d = S_WAIT_IRQ; end
            end
            S_WAIT_IRQ: begin
                if (irq_q) state_d = S_CHK_CMDR;
                else if (tmo_q == TW'(IRQ_TIMEOUT - 1)) begin
                    code_d = 2'd3;  state_d = S_FINISH;
                end else tmo_d = tmo_q + TW'(1);
            end
            S_CHK_CMDR: begin
                acc_req = 1'b1;  acc_adr = A_CMDR;
                if (ack_cyc) begin
                    if (ph_q == P_STOP) state_d = S_FINISH;
                    else if (dat_i[5]) begin code_d = 2'd2; state_d = S_FINISH; end
                    else if (dat_i[4] || !(dat_i[7] || dat_i[6])) begin
                        code_d = 2'd3;  state_d = S_FINISH;
                    end else if (dat_i[6]) begin code_d = 2'd1; state_d = S_STOP; end
                    else begin
                        case (ph_q)
                            P_BUS:   state_d = S_START;
                            P_START: state_d = S_ADDR;
                            P_ADDR:  state_d = (cnt_q == '0) ? S_STOP : (rd_q ? S_RDATA : S_WDATA);
                            P_WR: begin
                                cnt_d   = cnt_q - LEN_WIDTH'(1);
                                state_d = (cnt_q == LEN_WIDTH'(1)) ? S_STOP : S_WDATA;
                            end
                            P_RD:    state_d = S_RD_DPR;
                            default: state_d = S_FINISH;
                        endcase
                    end
                end
            end
            S_RD_DPR: begin
                acc_req = 1'b1;  acc_adr = A_DPR;
                if (ack_cyc) begin rdata_d = dat_i[7:0]; state_d = S_RD_OUT; end
            end
            S_RD_OUT: if (rd_ready_i) begin
                cnt_d   = cnt_q - LEN_WIDTH'(1);
                state_d = (cnt_q == LEN_WIDTH'(1)) ? S_STOP : S_RDATA;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_INIT_CSR;
        endcase

        // Single-access Wishbone engine: strobes drop after ack, and the next state can
        // only relaunch once cyc is low, which guarantees an idle cycle between accesses.
        if (cyc_q) begin
            if (ack_i) begin cyc_d = 1'b0; stb_d = 1'b0; we_d = 1'b0; end
        end else if (acc_req) begin
            cyc_d = 1'b1;  stb_d = 1'b1;  we_d = acc_we;  adr_d = acc_adr;  dat_d = acc_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_INIT_CSR;  ph_q <= P_BUS;  cmd_q <= '0;  bus_q <= '0;
            addr_q <= '0;  rd_q <= 1'b0;  cnt_q <= '0;  wbyte_q <= '0;  have_q <= 1'b0;
            rdata_q <= '0;  code_q <= '0;  tmo_q <= '0;  irq_q <= 1'b0;
            cyc_q <= 1'b0;  stb_q <= 1'b0;  we_q <= 1'b0;  adr_q <= '0;  dat_q <= '0;
        end else begin
            state_q <= state_d;  ph_q <= ph_d;  cmd_q <= cmd_d;  bus_q <= bus_d;
            addr_q <= addr_d;  rd_q <= rd_d;  cnt_q <= cnt_d;  wbyte_q <= wbyte_d;
            have_q <= have_d;  rdata_q <= rdata_d;  code_q <= code_d;  tmo_q <= tmo_d;
            irq_q <= irq_i;
            cyc_q <= cyc_d;  stb_q <= stb_d;  we_q <= we_d;  adr_q <= adr_d;  dat_q <= dat_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign wr_ready_o  = (state_q == S_WDATA) && !have_q;
    assign rd_valid_o  = (state_q == S_RD_OUT);
    assign rd_data_o   = rdata_q;
    assign done_o      = (state_q == S_FINISH);
    assign err_o       = done_o && (code_q != 2'd0);
    assign err_code_o  = code_q;
    assign cyc_o       = cyc_q;
    assign stb_o       = stb_q;
    assign we_o        = we_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Bench for i2cmb_wb_sequencer: behavioural iicmb controller + I2C slave model, random
// byte streams, and expected register traces built from the transaction description.
module tb_i2cmb_wb_sequencer;
    logic       clk = 0, rst_n = 0;
    logic       req_valid = 0, req_ready, req_rd = 0;
    logic [3:0] req_bus = 0;
    logic [6:0] req_addr = 0;
    logic [5:0] req_len = 0;
    logic       wr_valid = 0, wr_ready, rd_valid, rd_ready = 0;
    logic [7:0] wr_data = 0, rd_data, dat_o, dat_i;
    logic       done, err, cyc, stb, we, ack, irq;
    logic [1:0] err_code, adr;

    i2cmb_wb_sequencer #(.IRQ_TIMEOUT(300)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_bus_i(req_bus), .req_addr_i(req_addr), .req_rd_i(req_rd), .req_len_i(req_len),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .done_o(done), .err_o(err), .err_code_o(err_code),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o), .dat_i(dat_i),
        .ack_i(ack), .irq_i(irq));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [9:0] trace[$], exp_tr[$];
    logic [7:0] slv_rx[$], slv_tx[$], rd_got[$], exp_b[$];
    logic [7:0] wr_buf[64];
    int         wr_ptr = 0, wr_len = 0, stall_cycles = 0, hold_cnt = 0, rd_unstable = 0;
    int         rdv_cmd_viol = 0, irq_cnt = 0, lat = 0;
    logic [7:0] hold_val = 0, m_dpr = 0, m_status = 0;
    bit         addr_phase = 0, inject_al = 0, inject_to = 0;
    localparam logic [6:0] NAK_ADDR = 7'h10;

    // Controller + slave model: every WB write is logged; CMDR writes raise irq later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack <= 0; irq <= 0; dat_i <= 0; irq_cnt = 0; lat = 0; addr_phase = 0;
        end else begin
            if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0 && !inject_to) irq <= 1;
            end
            if (ack) ack <= 0;
            else if (cyc && stb) begin
                if (lat > 0) lat--;
                else begin
                    ack <= 1;
                    lat = $urandom_range(0, 2);
                    if (we) begin
                        trace.push_back({adr, dat_o});
                        if (adr == 2'd1) m_dpr = dat_o;
                        else if (adr == 2'd2) begin
                            if (rd_valid) rdv_cmd_viol++;
                            case (dat_o)
                                8'h04: begin m_status = 8'h80; addr_phase = 1; end
                                8'h06, 8'h05: m_status = 8'h80;
                                8'h01: begin
                                    if (addr_phase) begin
                                        addr_phase = 0;
                                        if (m_dpr[7:1] == NAK_ADDR) m_status = 8'h40;
                                        else if (inject_al) m_status = 8'h20;
                                        else m_status = 8'h80;
                                    end else begin
                                        slv_rx.push_back(m_dpr);
                                        m_status = 8'h80;
                                    end
                                end
                                8'h02, 8'h03: begin
                                    m_dpr = (slv_tx.size() > 0) ? slv_tx.pop_front() : 8'hEE;
                                    m_status = 8'h80;
                                end
                                default: m_status = 8'h10;
                            endcase
                            irq_cnt = $urandom_range(1, 6);
                        end
                    end else begin
                        if (adr == 2'd2) begin dat_i <= m_status; irq <= 0; end
                        else if (adr == 2'd1) dat_i <= m_dpr;
                        else dat_i <= 8'h00;
                    end
                end
            end
        end
    end

    // Write-byte source with random bubbles.
    always @(posedge clk) begin
        if (wr_valid && wr_ready) wr_ptr = wr_ptr + 1;
        if (wr_ptr < wr_len && $urandom_range(0, 3) != 0) begin
            wr_valid <= 1; wr_data <= wr_buf[wr_ptr];
        end else wr_valid <= 0;
    end

    // Read-byte sink; optional stall, and a stability watch while stalled.
    always @(posedge clk) begin
        if (rd_valid && rd_ready) begin
            rd_got.push_back(rd_data);
            hold_cnt = 0;
            rd_ready <= (stall_cycles == 0);
        end else if (rd_valid) begin
            if (hold_cnt == 0) hold_val = rd_data;
            else if (rd_data !== hold_val) rd_unstable++;
            hold_cnt++;
            rd_ready <= (hold_cnt >= stall_cycles);
        end else rd_ready <= (stall_cycles == 0);
    end

    logic       got_err, rr_at_done, rr_after, done_after;
    logic [1:0] got_code;

    function automatic void build_exp(input logic [3:0] b, input logic [6:0] a, input logic r,
                                      input int len, input int outcome);
        int n = (len > 32) ? 32 : len;
        exp_tr.delete(); exp_b.delete();
        exp_tr.push_back({2'd1, 4'h0, b}); exp_tr.push_back({2'd2, 8'h06});
        if (outcome == 3) return;
        exp_tr.push_back({2'd2, 8'h04}); exp_tr.push_back({2'd1, a, r});
        exp_tr.push_back({2'd2, 8'h01});
        if (outcome == 2) return;
        if (outcome == 1) begin exp_tr.push_back({2'd2, 8'h05}); return; end
        for (int i = 0; i < n; i++) begin
            if (!r) begin
                exp_tr.push_back({2'd1, wr_buf[i]}); exp_tr.push_back({2'd2, 8'h01});
                exp_b.push_back(wr_buf[i]);
            end else exp_tr.push_back({2'd2, (i == n - 1) ? 8'h03 : 8'h02});
        end
        exp_tr.push_back({2'd2, 8'h05});
    endfunction

    function automatic bit tr_eq();
        if (trace.size() != exp_tr.size()) return 0;
        foreach (trace[i]) if (trace[i] !== exp_tr[i]) return 0;
        return 1;
    endfunction

    function automatic bit bq_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] !== b[i]) return 0;
        return 1;
    endfunction

    task automatic send_req(input logic [3:0] b, input logic [6:0] a, input logic r, input int len);
        int n = 0;
        trace.delete(); slv_rx.delete(); rd_got.delete();
        wr_ptr = 0; wr_len = r ? 0 : len;
        while (!req_ready && n < 2000) begin @(negedge clk); n++; end
        req_bus = b; req_addr = a; req_rd = r; req_len = 6'(len); req_valid = 1;
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20000) begin @(negedge clk); n++; end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL done_wait got=%b exp=1", done); end
        got_err = err; got_code = err_code; rr_at_done = req_ready;
        @(negedge clk);
        rr_after = req_ready; done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({cyc, stb, we, adr, dat_o, req_ready, wr_ready, rd_valid, rd_data, done, err, err_code} !== 28'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0",
                {cyc, stb, we, adr, dat_o, req_ready, wr_ready, rd_valid, rd_data, done, err, err_code});
        end
        trace.delete();
        rst_n = 1;
        for (int n = 0; n < 200 && !req_ready; n++) @(negedge clk);
        exp_tr.delete(); exp_tr.push_back({2'd0, 8'hC0});
        total++;
        if (tr_eq() !== 1'b1) begin bad++; $display("FAIL init_csr got_n=%0d exp_n=1 ready=%b", trace.size(), req_ready); end
    endtask

    task automatic test_write32();
        for (int i = 0; i < 32; i++) wr_buf[i] = 8'(i);
        build_exp(4'd5, 7'h22, 1'b0, 32, 0);
        send_req(4'd5, 7'h22, 1'b0, 32);
        wait_done();
        total++; if (tr_eq() !== 1'b1) begin bad++; $display("FAIL wr32_trace got_n=%0d exp_n=%0d", trace.size(), exp_tr.size()); end
        total++; if (bq_eq(slv_rx, exp_b) !== 1'b1) begin bad++; $display("FAIL wr32_slave_bytes got_n=%0d exp_n=32", slv_rx.size()); end
        total++; if ({got_err, got_code} !== 3'b000) begin bad++; $display("FAIL wr32_err got=%b exp=000", {got_err, got_code}); end
        total++; if ({rr_at_done, rr_after, done_after} !== 3'b010) begin
            bad++; $display("FAIL done_pulse_ready got=%b exp=010", {rr_at_done, rr_after, done_after}); end
    endtask

    task automatic test_read(input int len, input int stall, input string nm);
        logic [7:0] src[$];
        stall_cycles = stall; rd_unstable = 0; rdv_cmd_viol = 0;
        slv_tx.delete();
        for (int i = 0; i < len; i++) begin
            src.push_back((len == 32) ? 8'(100 + i) : 8'($urandom));
            slv_tx.push_back(src[i]);
        end
        build_exp(4'd2, 7'h22, 1'b1, len, 0);
        send_req(4'd2, 7'h22, 1'b1, len);
        wait_done();
        total++; if (tr_eq() !== 1'b1) begin bad++; $display("FAIL %s_trace got_n=%0d exp_n=%0d", nm, trace.size(), exp_tr.size()); end
        total++; if (bq_eq(rd_got, src) !== 1'b1) begin bad++; $display("FAIL %s_rd_bytes got_n=%0d exp_n=%0d", nm, rd_got.size(), len); end
        total++; if ({got_err, rd_unstable, rdv_cmd_viol} !== {1'b0, 32'd0, 32'd0}) begin
            bad++; $display("FAIL %s_flow err=%b unstable=%0d cmd_while_valid=%0d exp=0", nm, got_err, rd_unstable, rdv_cmd_viol); end
        stall_cycles = 0;
    endtask

    task automatic test_error(input int outcome, input logic [6:0] a, input string nm);
        for (int i = 0; i < 4; i++) wr_buf[i] = 8'($urandom);
        inject_al = (outcome == 2); inject_to = (outcome == 3);
        build_exp(4'd7, a, 1'b0, 4, outcome);
        send_req(4'd7, a, 1'b0, 4);
        wait_done();
        total++; if (tr_eq() !== 1'b1) begin bad++; $display("FAIL %s_trace got_n=%0d exp_n=%0d", nm, trace.size(), exp_tr.size()); end
        total++; if ({got_err, got_code, 32'(slv_rx.size())} !== {1'b1, 2'(outcome), 32'd0}) begin
            bad++; $display("FAIL %s_code got=%b/%0d/%0d exp=1/%0d/0", nm, got_err, got_code, slv_rx.size(), outcome); end
        inject_al = 0; inject_to = 0;
    endtask

    task automatic test_len0();
        build_exp(4'd1, 7'h33, 1'b0, 0, 0);
        send_req(4'd1, 7'h33, 1'b0, 0);
        wait_done();
        total++; if (tr_eq() !== 1'b1) begin bad++; $display("FAIL len0_trace got_n=%0d exp_n=%0d", trace.size(), exp_tr.size()); end
        total++; if (got_err !== 1'b0) begin bad++; $display("FAIL len0_err got=%b exp=0", got_err); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            logic [3:0] b = 4'($urandom);
            logic [6:0] a = 7'($urandom_range(32, 127));
            logic       r = 1'($urandom);
            int         len = (k == 0) ? 40 : $urandom_range(0, 40);
            int         n = (len > 32) ? 32 : len;
            logic [7:0] src[$];
            for (int i = 0; i < 40; i++) wr_buf[i] = 8'($urandom);
            slv_tx.delete();
            for (int i = 0; i < n; i++) begin src.push_back(8'($urandom)); slv_tx.push_back(src[i]); end
            build_exp(b, a, r, len, 0);
            send_req(b, a, r, len);
            wait_done();
            total++;
            if (tr_eq() !== 1'b1 || bq_eq(r ? rd_got : slv_rx, r ? src : exp_b) !== 1'b1 || got_err !== 1'b0) begin
                bad++; $display("FAIL rand%0d rd=%b len=%0d trace_n=%0d exp_n=%0d err=%b exp_err=0",
                                k, r, len, trace.size(), exp_tr.size(), got_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 20; i++) wr_buf[i] = 8'($urandom);
        send_req(4'd3, 7'h44, 1'b0, 20);
        for (int n = 0; n < 5000 && slv_rx.size() < 10; n++) @(negedge clk);
        #2 rst_n = 0;
        #1;
        total++;
        if ({cyc, stb, we, adr, dat_o, req_ready, wr_ready, rd_valid, rd_data, done, err, err_code} !== 28'd0 || slv_rx.size() != 10) begin
            bad++; $display("FAIL mid_reset_outputs got=%h rx=%0d exp=0/10",
                {cyc, stb, we, adr, dat_o, req_ready, wr_ready, rd_valid, rd_data, done, err, err_code}, slv_rx.size());
        end
        wr_ptr = 0; wr_len = 0;
        repeat (2) @(negedge clk);
        trace.delete();
        rst_n = 1;
        for (int n = 0; n < 200 && !req_ready; n++) @(negedge clk);
        exp_tr.delete(); exp_tr.push_back({2'd0, 8'hC0});
        total++; if (tr_eq() !== 1'b1) begin bad++; $display("FAIL mid_reset_csr got_n=%0d exp_n=1", trace.size()); end
        wr_buf[0] = 8'hA5; wr_buf[1] = 8'h5A;
        build_exp(4'd3, 7'h44, 1'b0, 2, 0);
        send_req(4'd3, 7'h44, 1'b0, 2);
        wait_done();
        total++;
        if (tr_eq() !== 1'b1 || bq_eq(slv_rx, exp_b) !== 1'b1 || got_err !== 1'b0) begin
            bad++; $display("FAIL post_reset_write trace_n=%0d exp_n=%0d rx_n=%0d err=%b exp_err=0",
                            trace.size(), exp_tr.size(), slv_rx.size(), got_err);
        end
    endtask

    initial begin
        test_reset();
        test_write32();
        test_read(32, 0, "rd32");
        test_error(1, NAK_ADDR, "nak");
        test_read(4, 50, "rd_stall");
        test_len0();
        test_random();
        test_error(2, 7'h21, "arb_lost");
        test_error(3, 7'h21, "timeout");
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
